// File: rtl/tiny_nn_result_packer_if.sv
// Byte-in / word-out handshake bundle between the tiny-nn core side and the host side.
// The slave modport belongs to the result packer; the master modport is its environment.
interface tiny_nn_result_packer_if;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        byte_last_i;
    logic [15:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;

    modport slave (
        input  byte_i,
        input  byte_valid_i,
        input  byte_last_i,
        input  out_ready_i,
        output out_data_o,
        output out_valid_o
    );

    modport master (
        output byte_i,
        output byte_valid_i,
        output byte_last_i,
        output out_ready_i,
        input  out_data_o,
        input  out_valid_o
    );
endinterface

// File: rtl/tiny_nn_result_packer.sv
// Re-pairs the core's low-then-high result bytes into 16-bit words and buffers them
// in a small FIFO; words arriving while the FIFO is full are dropped and flagged.
module tiny_nn_result_packer #(
    parameter int unsigned FifoDepth  = 4,
    parameter int unsigned CountWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    tiny_nn_result_packer_if.slave         bus,
    input  logic                           clear_i,
    output logic [$clog2(FifoDepth+1)-1:0] level_o,
    output logic [CountWidth-1:0]          word_count_o,
    output logic                           overflow_o
);
    localparam int unsigned PtrW   = $clog2(FifoDepth);
    localparam int unsigned LevelW = $clog2(FifoDepth + 1);
    localparam logic [LevelW-1:0] LevelFull = LevelW'(FifoDepth);

    typedef enum logic {
        ExpectLo,
        ExpectHi
    } state_e;

    state_e                state_q, state_d;
    logic [7:0]            lo_q, lo_d;
    logic [15:0]           mem_q [FifoDepth];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LevelW-1:0]     level_q, level_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  overflow_q, overflow_d;

    logic        push_req;
    logic [15:0] push_word;
    logic        push_ok;
    logic        pop;
    logic        not_empty;

    assign not_empty = (level_q != '0);

    // Pairing FSM: clear wins over any coincident byte, which is simply discarded.
    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        push_req  = 1'b0;
        push_word = '0;
        if (clear_i) begin
            state_d = ExpectLo;
            lo_d    = '0;
        end else if (bus.byte_valid_i) begin
            unique case (state_q)
                ExpectLo: begin
                    if (bus.byte_last_i) begin
                        push_req  = 1'b1;
                        push_word = {8'h00, bus.byte_i};
                    end else begin
                        lo_d    = bus.byte_i;
                        state_d = ExpectHi;
                    end
                end
                ExpectHi: begin
                    push_req  = 1'b1;
                    push_word = {bus.byte_i, lo_q};
                    state_d   = ExpectLo;
                end
                default: state_d = ExpectLo;
            endcase
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign pop     = not_empty && bus.out_ready_i && !clear_i;
    assign push_ok = push_req && ((level_q != LevelFull) || pop);

    always_comb begin
        level_d    = level_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear_i) begin
            level_d    = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push_ok && !pop) begin
                level_d = level_q + LevelW'(1);
            end else if (pop && !push_ok) begin
                level_d = level_q - LevelW'(1);
            end
            if (push_ok) begin
                count_d = count_q + CountWidth'(1);
            end
            if (push_req && !push_ok) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ExpectLo;
            lo_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            level_q    <= level_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    assign bus.out_valid_o = not_empty;
    assign bus.out_data_o  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign level_o         = level_q;
    assign word_count_o    = count_q;
    assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_tiny_nn_result_packer.sv
// Directed bench for tiny_nn_result_packer: a per-cycle vector table plus hand-written
// sequences for counter wrap and asynchronous reset mid-pair.
module tb_tiny_nn_result_packer;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       clear_i = 1'b0;
    logic [2:0] level_o;
    logic [7:0] word_count_o;
    logic       overflow_o;

    tiny_nn_result_packer_if bus ();

    tiny_nn_result_packer #(
        .FifoDepth  (4),
        .CountWidth (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .bus          (bus.slave),
        .clear_i      (clear_i),
        .level_o      (level_o),
        .word_count_o (word_count_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        clr;
        logic        vld;
        logic        last;
        logic [7:0]  b;
        logic        rdy;
        logic        val_e;
        logic [15:0] data_e;
        logic [2:0]  lvl_e;
        logic [7:0]  cnt_e;
        logic        ov_e;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic clr, logic vld, logic last, logic [7:0] b, logic rdy,
                                logic val_e, logic [15:0] data_e, logic [2:0] lvl_e,
                                logic [7:0] cnt_e, logic ov_e);
        vec_t v;
        v.clr = clr; v.vld = vld; v.last = last; v.b = b; v.rdy = rdy;
        v.val_e = val_e; v.data_e = data_e; v.lvl_e = lvl_e; v.cnt_e = cnt_e; v.ov_e = ov_e;
        return v;
    endfunction

    // Packed observation: {valid, overflow, level, count, data}
    function automatic logic [28:0] obs();
        return {bus.out_valid_o, overflow_o, level_o, word_count_o, bus.out_data_o};
    endfunction

    task automatic check(input string nm, input logic [28:0] got, input logic [28:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got val=%b ov=%b lvl=%0d cnt=%0d data=%h, expected val=%b ov=%b lvl=%0d cnt=%0d data=%h",
                     nm, got[28], got[27], got[26:24], got[23:16], got[15:0],
                     exp[28], exp[27], exp[26:24], exp[23:16], exp[15:0]);
        end
    endtask

    task automatic drive(input logic clr, input logic vld, input logic last,
                         input logic [7:0] b, input logic rdy);
        clear_i          = clr;
        bus.byte_valid_i = vld;
        bus.byte_last_i  = last;
        bus.byte_i       = b;
        bus.out_ready_i  = rdy;
    endtask

    task automatic step(input logic clr, input logic vld, input logic last,
                        input logic [7:0] b, input logic rdy);
        @(negedge clk_i);
        drive(clr, vld, last, b, rdy);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Pair 0x34/0x12 with an idle cycle between the halves; then pop.
        vecs.push_back(mk(0, 1, 0, 8'h34, 1, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 1, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h12, 1, 1, 16'h1234, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 16'h0000, 0, 1, 0));
        // Five words into a 4-deep FIFO with no consumer: the fifth is dropped.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0));
        for (int w = 1; w <= 5; w++) begin
            vecs.push_back(mk(0, 1, 0, 8'(w), 0, w > 1, (w > 1) ? 16'h0001 : 16'h0000,
                              3'((w - 1 > 4) ? 4 : w - 1), 8'((w - 1 > 4) ? 4 : w - 1), 0));
            vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 16'h0001,
                              3'((w > 4) ? 4 : w), 8'((w > 4) ? 4 : w), w == 5));
        end
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 16'h0002, 3, 4, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 16'h0003, 2, 4, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 16'h0004, 1, 4, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 16'h0000, 0, 4, 1));
        // Full FIFO, pop coincides with the high byte of BEEF.
        vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 16'h0000, 0, 0, 0));
        for (int w = 1; w <= 4; w++) begin
            vecs.push_back(mk(0, 1, 0, 8'(8'h11 * w), 0, w > 1, (w > 1) ? 16'h1111 : 16'h0000,
                              3'(w - 1), 8'(w - 1), 0));
            vecs.push_back(mk(0, 1, 0, 8'(8'h11 * w), 0, 1, 16'h1111, 3'(w), 8'(w), 0));
        end
        vecs.push_back(mk(0, 1, 0, 8'hEF, 0, 1, 16'h1111, 4, 4, 0));
        vecs.push_back(mk(0, 1, 0, 8'hBE, 1, 1, 16'h2222, 4, 5, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 16'h3333, 3, 5, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 16'h4444, 2, 5, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 16'hBEEF, 1, 5, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 16'h0000, 0, 5, 0));
        // Lone byte with last=1 pushes a zero-extended word; pairing realigns.
        vecs.push_back(mk(0, 1, 1, 8'h7A, 0, 1, 16'h007A, 1, 6, 0));
        vecs.push_back(mk(0, 1, 0, 8'h11, 0, 1, 16'h007A, 1, 6, 0));
        vecs.push_back(mk(0, 1, 0, 8'h22, 0, 1, 16'h007A, 2, 7, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 1, 16'h2211, 1, 7, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 16'h0000, 0, 7, 0));
        // Clear mid-pair with a coincident byte; last on a high byte is ignored.
        vecs.push_back(mk(0, 1, 0, 8'h55, 0, 0, 16'h0000, 0, 7, 0));
        vecs.push_back(mk(1, 1, 0, 8'h66, 1, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 8'h01, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'h02, 0, 1, 16'h0201, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 16'h0000, 0, 0, 0));

        #12;
        check("reset_state", obs(), 29'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].clr, vecs[i].vld, vecs[i].last, vecs[i].b, vecs[i].rdy);
            check($sformatf("vec%0d", i), obs(),
                  {vecs[i].val_e, vecs[i].ov_e, vecs[i].lvl_e, vecs[i].cnt_e, vecs[i].data_e});
        end

        // 256 words streamed with a consumer always ready: counter wraps to 0.
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] lo, hi;
            lo = 8'(i);
            hi = ~lo;
            step(1'b0, 1'b1, 1'b0, lo, 1'b1);
            step(1'b0, 1'b1, 1'b0, hi, 1'b1);
            check($sformatf("wrap_word%0d", i), obs(),
                  {1'b1, 1'b0, 3'd1, 8'(i + 1), hi, lo});
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        check("wrap_end", obs(), {1'b0, 1'b0, 3'd0, 8'd0, 16'h0000});

        // Async reset mid-pair with a word buffered.
        step(1'b0, 1'b1, 1'b0, 8'h78, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h56, 1'b0);
        check("pre_reset", obs(), {1'b1, 1'b0, 3'd1, 8'd1, 16'h5678});
        step(1'b0, 1'b1, 1'b0, 8'h9A, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("async_reset", obs(), 29'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b0, 1'b1, 1'b0, 8'hCD, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'hEF, 1'b0);
        check("post_reset_pair", obs(), {1'b1, 1'b0, 3'd1, 8'd1, 16'hEFCD});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tiny_nn_result_packer.md
# tiny_nn_result_packer

Downstream companion to the tiny-nn core top level. The core emits each 16-bit FP result as two consecutive bytes on its 8-bit output, low byte first. This block re-pairs those bytes into 16-bit words and buffers them in a small FIFO. It presents the words to the host side over a valid/ready handshake and flags any word lost to a full buffer, because the core has no backpressure.

## Interface
- FifoDepth, 4: number of 16-bit word entries; power of two, >= 2.
- CountWidth, 8: width of the accepted-word counter.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous, active-low.
- byte_i  input  8  result byte from the core.
- byte_valid_i  input  1  byte_i carries a result byte this cycle (driven by the integrating logic from the core state/phase).
- byte_last_i  input  1  final byte of a result stream; sampled only when byte_valid_i=1.
- clear_i  input  1  synchronous clear of the whole block.
- out_data_o  output  16  FIFO head word {hi, lo}; 16'h0000 when out_valid_o=0.
- out_valid_o  output  1  FIFO non-empty.
- out_ready_i  input  1  consumer accepts the head word when out_valid_o=1.
- level_o  output  $clog2(FifoDepth+1)  number of words currently stored.
- word_count_o  output  CountWidth  words accepted into the FIFO since reset/clear; wraps modulo 2^CountWidth.
- overflow_o  output  1  sticky: at least one word was dropped.

## Operation
- Pairing FSM has two states, ExpectLo (the reset state) and ExpectHi.
- ExpectLo, byte_valid_i=1, byte_last_i=0: store byte_i in lo_q; go to ExpectHi. Nothing is pushed.
- ExpectLo, byte_valid_i=1, byte_last_i=1: push {8'h00, byte_i}; stay in ExpectLo.
- ExpectHi, byte_valid_i=1: push {byte_i, lo_q}; go to ExpectLo. byte_last_i has no further effect.
- byte_valid_i=0: no state change in either state.
- Pop occurs when out_valid_o && out_ready_i.
- Push is accepted when level < FifoDepth or a pop occurs in the same cycle.
  - When full with a simultaneous pop, the push is accepted and the level is unchanged.
- A push that is not accepted drops the word and sets overflow_o. word_count_o does not increment. The pairing FSM still advances normally.
- Each accepted push increments word_count_o by 1, wrapping from 2^CountWidth-1 to 0.
- level_o: +1 for an accepted push only, -1 for a pop only, unchanged for both or neither.
- FIFO order is strict first-in first-out. Read and write pointers wrap modulo FifoDepth.
- clear_i=1, with priority over all other inputs in that cycle:
  - FIFO emptied and FSM returned to ExpectLo.
  - lo_q discarded, overflow_o cleared, word_count_o set to 0.
  - A coincident byte is dropped without setting overflow. A coincident pop does not occur.
- overflow_o clears only on clear_i or reset.

## Timing
- Reset values:
  - out_valid_o=0, out_data_o=16'h0000, level_o=0
  - word_count_o=0, overflow_o=0, FSM=ExpectLo.
  - Reset is effective immediately (asynchronous assertion) and may occur mid-pair: the pending low byte is lost.
- Latency:
  - A word pushed in cycle N appears on out_data_o with out_valid_o=1 in cycle N+1.
  - There is no combinational bypass, even when the FIFO is empty.
- All outputs are driven from registers or from the FIFO head; there is no combinational path from byte_i or byte_valid_i to any output.
- out_ready_i may combinationally affect only the next-state logic, not outputs in the same cycle.
- Back-to-back operation:
  - Sustained input is one byte per cycle, i.e. one word every 2 cycles.
  - Sustained output is one word per cycle while out_ready_i=1.
  - The FIFO never overflows if out_ready_i is high at least every other cycle.
- Once out_valid_o=1, the head word is held stable until popped or cleared.

## Test plan
- Reset, then bytes 0x34, 0x12 on consecutive cycles, out_ready_i=1 -> out_valid_o rises the cycle after 0x12; out_data_o=16'h1234; word_count_o=1; level_o returns to 0 after the pop.
- out_ready_i=0; FifoDepth=4; stream 5 words (10 bytes) 16'h0001..16'h0005 -> level_o=4; overflow_o=1; word_count_o=4; then raise out_ready_i -> pops 0001, 0002, 0003, 0004 in order; 0005 is never seen.
- FIFO full; out_ready_i=1 in the same cycle as the high byte of 16'hBEEF arrives -> push accepted; level_o stays 4; overflow_o stays 0; BEEF is the last word popped.
- Byte 0x7A with byte_last_i=1 in ExpectLo -> word 16'h007A is pushed; the next bytes 0x11, 0x22 produce 16'h2211 (pairing realigned).
- Low byte 0x55 accepted, then clear_i=1 together with byte 0x66 -> level_o=0, word_count_o=0, overflow_o=0; the following bytes 0x01, 0x02 yield 16'h0201.
- word_count_o wrap: 256 words pushed and popped with CountWidth=8 -> word_count_o reads 0, no overflow; asynchronous reset asserted mid-pair -> all outputs return to reset values within the same cycle.
